// File: rtl/sram_is61_resp_32b.sv
// LSU data-memory responder: each 32-bit request runs as two 16-bit IS61WV25616 accesses and ends with o_ACK.
// Optional build macro SRAM_BMASK_SKIP_EN skips write half-phases whose byte mask is zero.
module sram_is61_resp_32b #(
  parameter int WAIT_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_ADDR,
  input  logic [31:0] i_WDATA,
  input  logic [3:0]  i_BMASK,
  input  logic        i_WREN,
  input  logic        i_RDEN,
  output logic [31:0] o_RDATA,
  output logic        o_ACK,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_LO = 3'd1;
  localparam logic [2:0] S_WR_HI = 3'd2;
  localparam logic [2:0] S_RD_LO = 3'd3;
  localparam logic [2:0] S_RD_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Write phases last WAIT_CYC+1 cycles (extra hold cycle), read phases WAIT_CYC cycles.
  localparam logic [2:0] WR_LAST = 3'(WAIT_CYC);
  localparam logic [2:0] RD_LAST = 3'(WAIT_CYC - 1);

  logic [2:0]  state_q, state_nx;
  logic [2:0]  cnt_q, cnt_nx;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        is_wr_q;
  logic [15:0] rd_lo_q;
  logic        dq_oe_q;
  logic [15:0] dq_out_q;

  logic        req, accept, match;
  logic [15:0] word_e;
  logic [31:0] wdata_e;
  logic [3:0]  mask_e;
  logic [17:0] addr_nx;
  logic [15:0] dq_out_nx;
  logic        dq_oe_nx, ce_nx, we_nx, oe_nx, lb_nx, ub_nx;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^i_ADDR[1:0];

  function automatic logic [2:0] wr_first(input logic [3:0] m);
`ifdef SRAM_BMASK_SKIP_EN
    if (m[1:0] != 2'b00)      return S_WR_LO;
    else if (m[3:2] != 2'b00) return S_WR_HI;
    else                      return S_DONE;
`else
    logic unused_m;
    unused_m = ^m;
    return S_WR_LO;
`endif
  endfunction

  function automatic logic [2:0] wr_after_lo(input logic [3:0] m);
`ifdef SRAM_BMASK_SKIP_EN
    return (m[3:2] != 2'b00) ? S_WR_HI : S_DONE;
`else
    logic unused_m;
    unused_m = ^m;
    return S_WR_HI;
`endif
  endfunction

  assign req    = i_WREN | i_RDEN;
  assign accept = (state_q == S_IDLE) && req;

  // Values seen by the output decode: the request being accepted this edge, else the latched one.
  assign word_e  = accept ? i_ADDR[17:2] : addr_q;
  assign wdata_e = accept ? i_WDATA      : wdata_q;
  assign mask_e  = accept ? i_BMASK      : mask_q;

  assign match = (i_ADDR[17:2] == addr_q) && (i_WREN == is_wr_q) &&
                 (!is_wr_q || ((i_WDATA == wdata_q) && (i_BMASK == mask_q)));
  assign o_ACK = (state_q == S_DONE) && match;

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        cnt_nx = 3'd0;
        if (req) state_nx = i_WREN ? wr_first(i_BMASK) : S_RD_LO;
      end
      S_WR_LO: if (cnt_q == WR_LAST) begin
        cnt_nx   = 3'd0;
        state_nx = wr_after_lo(mask_q);
      end
      S_WR_HI: if (cnt_q == WR_LAST) begin
        cnt_nx   = 3'd0;
        state_nx = S_DONE;
      end
      S_RD_LO: if (cnt_q == RD_LAST) begin
        cnt_nx   = 3'd0;
        state_nx = S_RD_HI;
      end
      S_RD_HI: if (cnt_q == RD_LAST) begin
        cnt_nx   = 3'd0;
        state_nx = S_DONE;
      end
      default: begin
        cnt_nx   = 3'd0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Pin values for the cycle being entered, so every SRAM pin comes straight from a flop.
  always_comb begin
    addr_nx   = SRAM_ADDR;
    dq_out_nx = dq_out_q;
    dq_oe_nx  = 1'b0;
    ce_nx     = 1'b1;
    we_nx     = 1'b1;
    oe_nx     = 1'b1;
    lb_nx     = 1'b1;
    ub_nx     = 1'b1;
    case (state_nx)
      S_WR_LO, S_WR_HI: begin
        addr_nx   = {1'b0, word_e, state_nx == S_WR_HI};
        dq_out_nx = (state_nx == S_WR_HI) ? wdata_e[31:16] : wdata_e[15:0];
        dq_oe_nx  = 1'b1;
        ce_nx     = 1'b0;
        we_nx     = (cnt_nx == WR_LAST);
        lb_nx     = (state_nx == S_WR_HI) ? ~mask_e[2] : ~mask_e[0];
        ub_nx     = (state_nx == S_WR_HI) ? ~mask_e[3] : ~mask_e[1];
      end
      S_RD_LO, S_RD_HI: begin
        addr_nx = {1'b0, word_e, state_nx == S_RD_HI};
        ce_nx   = 1'b0;
        oe_nx   = 1'b0;
        lb_nx   = 1'b0;
        ub_nx   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 32'd0;
      mask_q    <= 4'd0;
      is_wr_q   <= 1'b0;
      rd_lo_q   <= 16'd0;
      o_RDATA   <= 32'd0;
      SRAM_ADDR <= 18'd0;
      dq_out_q  <= 16'd0;
      dq_oe_q   <= 1'b0;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      SRAM_ADDR <= addr_nx;
      dq_out_q  <= dq_out_nx;
      dq_oe_q   <= dq_oe_nx;
      SRAM_CE_N <= ce_nx;
      SRAM_WE_N <= we_nx;
      SRAM_OE_N <= oe_nx;
      SRAM_LB_N <= lb_nx;
      SRAM_UB_N <= ub_nx;
      if (accept) begin
        addr_q  <= i_ADDR[17:2];
        wdata_q <= i_WDATA;
        mask_q  <= i_BMASK;
        is_wr_q <= i_WREN;
      end
      if (state_q == S_RD_LO && cnt_q == RD_LAST) rd_lo_q <= SRAM_DQ;
      if (state_q == S_RD_HI && cnt_q == RD_LAST) o_RDATA <= {SRAM_DQ, rd_lo_q};
    end
  end

  assign SRAM_DQ = dq_oe_q ? dq_out_q : 16'bz;

endmodule

// File: tb/tb_sram_is61_resp_32b.sv
// Directed bench for sram_is61_resp_32b: a WAIT_CYC=1 instance on a behavioural SRAM and a WAIT_CYC=3 read instance.
module tb_sram_is61_resp_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        wren, rden;
  logic [31:0] rdata;
  logic        ack;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;

  logic [17:0] addr3;
  logic        rden3;
  logic [31:0] rdata3;
  logic        ack3;
  logic [17:0] sram_addr3;
  wire  [15:0] sram_dq3;
  logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;

  logic [15:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_is61_resp_32b #(.WAIT_CYC(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_ADDR(addr), .i_WDATA(wdata), .i_BMASK(bmask),
    .i_WREN(wren), .i_RDEN(rden), .o_RDATA(rdata), .o_ACK(ack),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  sram_is61_resp_32b #(.WAIT_CYC(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_ADDR(addr3), .i_WDATA(32'd0), .i_BMASK(4'd0),
    .i_WREN(1'b0), .i_RDEN(rden3), .o_RDATA(rdata3), .o_ACK(ack3),
    .SRAM_ADDR(sram_addr3), .SRAM_DQ(sram_dq3), .SRAM_CE_N(ce3_n), .SRAM_WE_N(we3_n),
    .SRAM_OE_N(oe3_n), .SRAM_LB_N(lb3_n), .SRAM_UB_N(ub3_n)
  );

  // Behavioural async SRAM: reads are combinational, writes land while CE_N and WE_N are both low.
  assign sram_dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'bz;
  assign sram_dq3 = (!ce3_n && !oe3_n) ? {8'hA0, sram_addr3[7:0]} : 16'bz;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[16] <= 16'h1111;
      mem[17] <= 16'h2222;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // W=1 read held until ACK; OE_N low in cycles 1-2, ACK and data in cycle 3.
  task automatic do_read(input logic [17:0] a, input logic [31:0] exp);
    addr = a; rden = 1'b1; wren = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rd_oe_n", 32'(oe_n), 32'(k >= 3));
      chk("rd_ack", 32'(ack), 32'(k == 3));
    end
    chk("rd_data", rdata, exp);
    rden = 1'b0;
    step();
    step();
    chk("rd_hold", rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_falls;
    logic prev_we;
    int ackc;

    rst = 1'b1; addr = '0; wdata = '0; bmask = '0; wren = 1'b0; rden = 1'b0;
    addr3 = '0; rden3 = 1'b0;
    step();
    step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    chk("rst_dq_oe", 32'(dut1.dq_oe_q), 32'h0);
    rst = 1'b0;
    step();

    // Full write of 0xDEADBEEF to word 4 (half-addresses 8 and 9).
    addr = 18'h00010; wdata = 32'hDEADBEEF; bmask = 4'hF; wren = 1'b1;
    we_falls = 0; prev_we = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("wr_ack", 32'(ack), 32'(k == 5));
      chk("wr_ce_n", 32'(ce_n), 32'(k == 5));
      if (!we_n && prev_we) we_falls++;
      prev_we = we_n;
      if (k == 1) chk("wr_addr_lo", 32'(sram_addr), 32'h8);
      if (k == 3) chk("wr_addr_hi", 32'(sram_addr), 32'h9);
    end
    chk("wr_we_pulses", 32'(we_falls), 32'd2);
    wren = 1'b0;
    step();
    chk("mem8", 32'(mem[8]), 32'hBEEF);
    chk("mem9", 32'(mem[9]), 32'hDEAD);

    do_read(18'h00010, 32'hDEADBEEF);

    // Lane-0-only write.
`ifdef SRAM_BMASK_SKIP_EN
    ackc = 3;
`else
    ackc = 5;
`endif
    addr = 18'h00010; wdata = 32'h00000055; bmask = 4'b0001; wren = 1'b1;
    for (int k = 1; k <= ackc; k++) begin
      step();
      chk("mwr_ack", 32'(ack), 32'(k == ackc));
      if (k == 3) chk("mwr_hi_ce_n", 32'(ce_n), 32'(ackc == 3));
    end
    wren = 1'b0;
    step();
    chk("mwr_rdata_kept", rdata, 32'hDEADBEEF);
    chk("mwr_mem8", 32'(mem[8]), 32'hBE55);
    chk("mwr_mem9", 32'(mem[9]), 32'hDEAD);
    step();
    do_read(18'h00010, 32'hDEADBE55);

    // Stale read: request switches to a write while RD_HI is running.
    addr = 18'h00020; rden = 1'b1;
    step();
    step();
    rden = 1'b0; wren = 1'b1; addr = 18'h00010; wdata = 32'hCAFEF00D; bmask = 4'hF;
    step();
    chk("stale_done_ack", 32'(ack), 32'h0);
    chk("stale_rdata", rdata, 32'h22221111);
    step();
    chk("stale_idle_ack", 32'(ack), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("reacc_ack", 32'(ack), 32'(k == 5));
    end
    wren = 1'b0;
    step();
    chk("reacc_mem8", 32'(mem[8]), 32'hF00D);
    chk("reacc_mem9", 32'(mem[9]), 32'hCAFE);
    step();

    // Reset while in WR_HI.
    addr = 18'h00010; wdata = 32'h12345678; bmask = 4'hF; wren = 1'b1;
    step();
    step();
    step();
    chk("mid_hi_ce_n", 32'(ce_n), 32'h0);
    chk("mid_hi_addr", 32'(sram_addr), 32'h9);
    rst = 1'b1;
    step();
    chk("mid_rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    chk("mid_rst_dq_oe", 32'(dut1.dq_oe_q), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    rst = 1'b0; wren = 1'b0;
    step();
    chk("post_rst_ack", 32'(ack), 32'h0);

    // WAIT_CYC=3 read of word 8: OE_N low for six cycles, ACK in cycle 7.
    addr3 = 18'h00020; rden3 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("w3_oe_n", 32'(oe3_n), 32'(k > 6));
      chk("w3_ack", 32'(ack3), 32'(k == 7));
    end
    chk("w3_rdata", rdata3, 32'hA011A010);
    rden3 = 1'b0;
    step();
    chk("w3_idle_ack", 32'(ack3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
